key_cmd_decoder: RTL

- Sits between the Nios keycode PIO export (16 bits, two USB HID usage codes) and Game_Controller.
- Converts the raw keycodes into per-frame, registered tank commands for two players: direction plus fire.
- Commands update once per frame, on the start of vertical sync, so game logic sees stable inputs for the whole frame.
- Applies last-pressed-wins direction arbitration and a per-player fire cooldown counted in frames.

---
 rtl/battlecity_pkg.sv | 43 ++++
 rtl/player_cmd.sv | 75 +++++++
 rtl/key_cmd_decoder.sv | 59 +++++
 3 files changed

// File: rtl/battlecity_pkg.sv
// Shared Battle City types: tank direction encoding and the USB HID key codes
// used by the player command decoder and Game_Controller.
package battlecity_pkg;

    typedef enum logic [2:0] {
        DIR_NONE  = 3'd0,
        DIR_UP    = 3'd1,
        DIR_DOWN  = 3'd2,
        DIR_LEFT  = 3'd3,
        DIR_RIGHT = 3'd4
    } dir_t;

    localparam logic [7:0] KEY_W     = 8'h1A;
    localparam logic [7:0] KEY_S     = 8'h16;
    localparam logic [7:0] KEY_A     = 8'h04;
    localparam logic [7:0] KEY_D     = 8'h07;
    localparam logic [7:0] KEY_SPACE = 8'h2C;
    localparam logic [7:0] KEY_UP    = 8'h52;
    localparam logic [7:0] KEY_DOWN  = 8'h51;
    localparam logic [7:0] KEY_LEFT  = 8'h50;
    localparam logic [7:0] KEY_RIGHT = 8'h4F;
    localparam logic [7:0] KEY_ENTER = 8'h28;

    // Direction masks are ordered [3] up, [2] down, [1] left, [0] right.
    function automatic dir_t pick_dir(input logic [3:0] m);
        if (m[3])      return DIR_UP;
        else if (m[2]) return DIR_DOWN;
        else if (m[1]) return DIR_LEFT;
        else if (m[0]) return DIR_RIGHT;
        else           return DIR_NONE;
    endfunction

    function automatic logic dir_held(input dir_t d, input logic [3:0] m);
        case (d)
            DIR_UP:    return m[3];
            DIR_DOWN:  return m[2];
            DIR_LEFT:  return m[1];
            DIR_RIGHT: return m[0];
            default:   return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/player_cmd.sv
// One player's key match, last-pressed-wins direction arbitration and
// frame-counted fire cooldown; state advances only on the frame tick.
module player_cmd
    import battlecity_pkg::*;
#(
    parameter logic [7:0]  K_UP            = KEY_W,
    parameter logic [7:0]  K_DOWN          = KEY_S,
    parameter logic [7:0]  K_LEFT          = KEY_A,
    parameter logic [7:0]  K_RIGHT         = KEY_D,
    parameter logic [7:0]  K_FIRE          = KEY_SPACE,
    parameter int unsigned COOLDOWN_FRAMES = 30,
    parameter int unsigned CD_W            = 6
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tick,
    input  logic [15:0] keys,
    output logic [2:0]  dir,
    output logic        fire
);

    dir_t            dir_q, dir_d;
    logic [3:0]      prev_mask;
    logic [3:0]      mask, new_m;
    logic [CD_W-1:0] cd_q, cd_d;
    logic            prev_fire, fire_held, press;
    logic            fire_q, fire_d;

    // A code in both slots just ORs into the same bit, so it counts once.
    function automatic logic hit(input logic [7:0] code);
        return (keys[7:0] == code) || (keys[15:8] == code);
    endfunction

    always_comb begin
        mask      = {hit(K_UP), hit(K_DOWN), hit(K_LEFT), hit(K_RIGHT)};
        fire_held = hit(K_FIRE);
        new_m     = mask & ~prev_mask;
        press     = fire_held & ~prev_fire;

        dir_d = dir_q;
        if (new_m != '0)
            dir_d = pick_dir(new_m);
        else if (!dir_held(dir_q, mask))
            dir_d = pick_dir(mask);

        fire_d = 1'b0;
        cd_d   = cd_q;
        if (press && cd_q == '0) begin
            fire_d = 1'b1;
            cd_d   = CD_W'(COOLDOWN_FRAMES);
        end else if (cd_q != '0) begin
            cd_d = cd_q - CD_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dir_q     <= DIR_NONE;
            prev_mask <= '0;
            cd_q      <= '0;
            prev_fire <= 1'b0;
            fire_q    <= 1'b0;
        end else if (tick) begin
            dir_q     <= dir_d;
            prev_mask <= mask;
            cd_q      <= cd_d;
            prev_fire <= fire_held;
            fire_q    <= fire_d;
        end
    end

    assign dir  = dir_q;
    assign fire = fire_q;

endmodule

// File: rtl/key_cmd_decoder.sv
// Keycode register, vsync synchronizer and frame tick feeding two per-player
// command decoders; commands change only once per frame.
module key_cmd_decoder
    import battlecity_pkg::*;
#(
    parameter int unsigned COOLDOWN_FRAMES = 30,
    parameter int unsigned CD_W            = 6
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic [15:0] keycode,
    input  logic        vs,
    output logic [2:0]  p1_dir,
    output logic        p1_fire,
    output logic [2:0]  p2_dir,
    output logic        p2_fire,
    output logic        cmd_valid
);

    logic [15:0] kc_q;
    logic        s1, s2, s3;
    logic        tick;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            kc_q      <= '0;
            s1        <= 1'b1;
            s2        <= 1'b1;
            s3        <= 1'b1;
            cmd_valid <= 1'b0;
        end else begin
            kc_q      <= keycode;
            s1        <= vs;
            s2        <= s1;
            s3        <= s2;
            cmd_valid <= tick;
        end
    end

    // s1 absorbs metastability; the edge is detected between s2 and s3.
    assign tick = s3 & ~s2;

    player_cmd #(
        .K_UP(KEY_W), .K_DOWN(KEY_S), .K_LEFT(KEY_A), .K_RIGHT(KEY_D),
        .K_FIRE(KEY_SPACE), .COOLDOWN_FRAMES(COOLDOWN_FRAMES), .CD_W(CD_W)
    ) u_p1 (
        .clk(Clk), .rst_n(Reset_n), .tick(tick), .keys(kc_q),
        .dir(p1_dir), .fire(p1_fire)
    );

    player_cmd #(
        .K_UP(KEY_UP), .K_DOWN(KEY_DOWN), .K_LEFT(KEY_LEFT), .K_RIGHT(KEY_RIGHT),
        .K_FIRE(KEY_ENTER), .COOLDOWN_FRAMES(COOLDOWN_FRAMES), .CD_W(CD_W)
    ) u_p2 (
        .clk(Clk), .rst_n(Reset_n), .tick(tick), .keys(kc_q),
        .dir(p2_dir), .fire(p2_fire)
    );

endmodule
